kbbuf_fifo: RTL

KBBUF_FIFO -- requirements
Module: kbbuf_fifo

---
 rtl/kbbuf_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/kbbuf_fifo.sv
// Keyboard byte FIFO: circular buffer with registered first-word-fall-through head, occupancy count and sticky overflow.
// Define KBBUF_OVERWRITE_EN to make a write into a full FIFO replace the oldest entry instead of being dropped.
module kbbuf_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            kbbuf_data,
  input  logic                  kbbuf_wren,
  input  logic                  rd_pop,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic [7:0]            rd_data,
  output logic                  rd_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [DEPTH_LOG2:0]   count_n;
  logic                  full, do_pop, do_write, ovf_set, rd_adv;
  logic [7:0]            head_n;

  always_comb begin
    full    = (count == FULL_CNT);
    do_pop  = rd_pop && (count != '0);
    // a pop in the same cycle frees the slot, so only a pop-less write to a full FIFO overflows
    ovf_set = kbbuf_wren && full && !rd_pop;
`ifdef KBBUF_OVERWRITE_EN
    do_write = kbbuf_wren;
    rd_adv   = do_pop || ovf_set;
`else
    do_write = kbbuf_wren && !ovf_set;
    rd_adv   = do_pop;
`endif
    wr_ptr_n = wr_ptr + DEPTH_LOG2'(do_write);
    rd_ptr_n = rd_ptr + DEPTH_LOG2'(rd_adv);
    count_n  = count + (DEPTH_LOG2 + 1)'(do_write) - (DEPTH_LOG2 + 1)'(rd_adv);
    // bypass the RAM when the new head is the byte being written this cycle
    head_n   = (do_write && (wr_ptr == rd_ptr_n)) ? kbbuf_data : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && do_write)
      mem[wr_ptr] <= kbbuf_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_empty <= 1'b1;
      overflow <= 1'b0;
      rd_data  <= 8'h00;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      rd_empty <= (count_n == '0);
      if (count_n != '0)
        rd_data <= head_n;
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule
